ram8_word_store: RTL and testbench

Eight-word by 16-bit register file with a single write port, a registered read port and a self-timed clear sequencer. It is the storage element above the 16-bit gate layer: address decode steers `load` to one word (demultiplex direction) and a read mux returns one word. It is the first clocked block in the gates/storage hierarchy and the base for larger RAM stacks.

---
 rtl/ram8_word_store.sv | 61 ++++++
 tb/tb_ram8_word_store.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram8_word_store.sv
// ram8_word_store: 8x16 register file with registered read port and self-timed clear sequencer.
// Define RAM8_READ_BYPASS_EN for write-first reads on a same-address collision; default is read-first.
module ram8_word_store #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);
  typedef enum logic {IDLE, CLEARING} state_t;
  state_t           state, state_n;
  logic [2:0]       clr_idx, idx_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [2:0]       wa;
  logic [WIDTH-1:0] wd, rd;
  // One shared write port: user writes in IDLE, zero writes while clearing.
  always_comb begin
    state_n = state;
    idx_n   = clr_idx;
    we      = 1'b0;
    wa      = address;
    wd      = data_in;
    if (state == IDLE) begin
      state_n = clear ? CLEARING : IDLE;
      idx_n   = '0;
      we      = load && !clear;
    end else begin
      we      = 1'b1;
      wa      = clr_idx;
      wd      = '0;
      idx_n   = clr_idx + 3'd1;
      state_n = (clr_idx == 3'd7) ? IDLE : CLEARING;
    end
  end
`ifdef RAM8_READ_BYPASS_EN
  assign rd = (we && wa == address) ? wd : mem[address];
`else
  assign rd = mem[address];
`endif
  assign busy = (state == CLEARING);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_idx  <= '0;
      data_out <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state    <= state_n;
      clr_idx  <= idx_n;
      data_out <= rd;
      if (we) mem[wa] <= wd;
    end
  end
endmodule

// File: tb/tb_ram8_word_store.sv
// tb_ram8_word_store: scoreboard-driven bench for ram8_word_store; expected read data is queued when addresses are driven.
module tb_ram8_word_store;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic        clear = 1'b0;
  logic [15:0] data_out;
  logic        busy;
  logic [15:0] exp_q [$];
  logic [15:0] exp_v;
  int errors = 0;
  int checks = 0;

  ram8_word_store dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load),
    .address(address), .clear(clear), .data_out(data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [15:0] v);
    load = 1'b1;
    data_in = v;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      tick();
    end
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++;
    if (data_out !== 16'h0) begin errors++; $display("FAIL reset_dout got=%h want=0000", data_out); end
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      exp_q.push_back(16'h0000);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin errors++; $display("FAIL reset_read[%0d] got=%h want=%h", a, data_out, exp_v); end
    end
  endtask

  task automatic test_write_read();
    load = 1'b1; address = 3'd3; data_in = 16'hA5A5; tick();
    address = 3'd7; data_in = 16'h1234; tick();
    load = 1'b0;
    address = 3'd3; exp_q.push_back(16'hA5A5); tick();
    address = 3'd7; exp_q.push_back(16'h1234);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL read_a3 got=%h want=%h", data_out, exp_v); end
    tick();
    address = 3'd0; exp_q.push_back(16'h0000);
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL read_a7 got=%h want=%h", data_out, exp_v); end
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL read_a0 got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_collision();
    load = 1'b1; address = 3'd5; data_in = 16'h00FF; tick();
    data_in = 16'hBEEF;
`ifdef RAM8_READ_BYPASS_EN
    exp_q.push_back(16'hBEEF);
`else
    exp_q.push_back(16'h00FF);
`endif
    tick();
    load = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL collide_same_edge got=%h want=%h", data_out, exp_v); end
    exp_q.push_back(16'hBEEF);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL collide_next got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_clear();
    int cnt;
    fill(16'hFFFF);
    clear = 1'b1; tick();
    clear = 1'b0;
    load = 1'b1; address = 3'd2; data_in = 16'h5555;
    cnt = 0;
    while (busy && cnt < 20) begin
      clear = (cnt == 3);
      cnt++;
      tick();
    end
    load = 1'b0; clear = 1'b0;
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL clear_busy_len got=%0d want=8", cnt); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL clear_no_restart got=%b want=0", busy); end
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      exp_q.push_back(16'h0000);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin errors++; $display("FAIL clear_read[%0d] got=%h want=%h", a, data_out, exp_v); end
      if (a == 2) begin
        checks++;
        if (data_out === 16'h5555) begin errors++; $display("FAIL clear_load_ignored got=%h want=not 5555", data_out); end
      end
    end
  endtask

  task automatic test_load_clear();
    int cnt;
    load = 1'b1; clear = 1'b1; address = 3'd4; data_in = 16'h7777; tick();
    load = 1'b0; clear = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL lc_busy got=%b want=1", busy); end
    cnt = 0;
    while (busy && cnt < 20) begin cnt++; tick(); end
    checks++;
    if (cnt !== 8) begin errors++; $display("FAIL lc_busy_len got=%0d want=8", cnt); end
    exp_q.push_back(16'h0000);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (data_out !== exp_v) begin errors++; $display("FAIL lc_read_a4 got=%h want=%h", data_out, exp_v); end
  endtask

  task automatic test_reset_mid_clear();
    fill(16'h1111);
    address = 3'd5;
    clear = 1'b1; tick();
    clear = 1'b0;
    tick();
    tick();
    checks++;
    if (data_out !== 16'h1111 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got=%h/%b want=1111/1", data_out, busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    checks++;
    if (data_out !== 16'h0) begin errors++; $display("FAIL mid_rst_dout got=%h want=0000", data_out); end
    #1 rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      exp_q.push_back(16'h0000);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (data_out !== exp_v) begin errors++; $display("FAIL mid_read[%0d] got=%h want=%h", a, data_out, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_clear();
    test_load_clear();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
